// File: rtl/vpp_meter_pkg.sv
// ============================================================================
// Module : vpp_meter_pkg
// Brief  : Shared widths, FSM encoding and helpers for the peak-to-peak meter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vpp_meter_pkg;

    localparam int c_PP_W   = 9;
    localparam int c_ACC_W  = 13;
    localparam int c_PROD_W = 25;
    localparam int c_OUT_W  = 16;
    localparam int c_MVQ_W  = 16;

    localparam logic [c_OUT_W-1:0] c_SAT_MV = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_MUL  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Inverted codes (e.g. min still all-ones after reset) read as zero amplitude.
    function automatic logic [c_PP_W-1:0] pp_clamp(input logic [c_PP_W-1:0] max_c,
                                                   input logic [c_PP_W-1:0] min_c);
        return (max_c >= min_c) ? (max_c - min_c) : '0;
    endfunction

    function automatic logic [c_OUT_W-1:0] sat_mv(input logic [c_PROD_W-c_PP_W+c_PP_W-1:0] prod);
        logic [c_PROD_W-9:0] res;
        res = prod[c_PROD_W-1:8];
        return res[c_PROD_W-9] ? c_SAT_MV : res[c_OUT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vpp_meter_if.sv
// ============================================================================
// Module : vpp_meter_if
// Brief  : Quantiser codes in, millivolt result out with valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vpp_meter_if;
    import vpp_meter_pkg::*;

    logic [c_PP_W-1:0]  max_code;
    logic [c_PP_W-1:0]  min_code;
    logic [c_OUT_W-1:0] vpp_mv;
    logic               out_vld;
    logic               out_rdy;
    logic               overrun;
    logic               busy;

    modport master (
        input  max_code, min_code, out_rdy,
        output vpp_mv, out_vld, overrun, busy
    );

    modport slave (
        output max_code, min_code, out_rdy,
        input  vpp_mv, out_vld, overrun, busy
    );

endinterface

`default_nettype wire

// File: rtl/vpp_meter_seq_mul.sv
// ============================================================================
// Module : vpp_seq_mul
// Brief  : 9x16 serial shift-add multiplier, LSB first, 9 cycles from start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vpp_seq_mul
    import vpp_meter_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 start,
    input  wire  [c_PP_W-1:0]   a,
    input  wire  [c_MVQ_W-1:0]  b,
    output logic                done,
    output logic [c_PROD_W-1:0] p
);

    logic [c_PP_W-1:0]   r_a;
    logic [c_PROD_W-1:0] r_b;
    logic [c_PROD_W-1:0] r_prod;
    logic [3:0]          r_cnt;
    logic                r_run;

    logic [c_PROD_W-1:0] w_b_ext;

    assign w_b_ext = {{(c_PROD_W-c_MVQ_W){1'b0}}, b};

    // Bit 0 is consumed in the start cycle so bit 8 lands on the 9th cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (start) begin
            r_prod <= a[0] ? w_b_ext : '0;
            r_a    <= {1'b0, a[c_PP_W-1:1]};
            r_b    <= {w_b_ext[c_PROD_W-2:0], 1'b0};
            r_cnt  <= 4'd1;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_prod <= r_prod + (r_a[0] ? r_b : '0);
            r_a    <= {1'b0, r_a[c_PP_W-1:1]};
            r_b    <= {r_b[c_PROD_W-2:0], 1'b0};
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'd8) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done = r_run && !start && (r_cnt == 4'd8);
    assign p    = r_prod;

endmodule

`default_nettype wire

// File: rtl/vpp_meter.sv
// ============================================================================
// Module : vpp_meter
// Brief  : Samples max/min codes, averages pp, scales to mV, valid/ready out.
//          Optional hysteresis filter enabled by macro VPP_METER_HYST_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vpp_meter
    import vpp_meter_pkg::*;
#(
    parameter int           SAMPLE_PERIOD = 1_000_000,
    parameter int           AVG_LOG2      = 2,
    parameter logic [15:0]  MV_PER_LSB_Q8 = 16'd1024,
    parameter logic [15:0]  HYST_MV       = 16'd8
)(
    input  wire             clk,
    input  wire             rst,
    vpp_meter_if.master     bus
);

    localparam int                 c_CNT_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]         c_N_LAST   = 5'((1 << AVG_LOG2) - 1);

    logic [c_CNT_W-1:0]  r_per_cnt;
    logic [4:0]          r_ncnt;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_PP_W-1:0]   r_avg;
    state_t              r_state;
    logic                r_mul_start;
    logic                r_busy;
    logic                r_vld;
    logic                r_ovr;
    logic [c_OUT_W-1:0]  r_vpp;

    logic                w_tick;
    logic                w_group_done;
    logic [c_PP_W-1:0]   w_pp;
    logic [c_ACC_W-1:0]  w_acc_sum;
    logic [c_ACC_W-1:0]  w_avg_wide;
    logic                w_mul_done;
    logic [c_PROD_W-1:0] w_prod;
    logic [c_OUT_W-1:0]  w_res_sat;
    logic                w_update;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
        end else if (r_per_cnt == c_CNT_LAST) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
        end
    end

    assign w_tick       = (r_per_cnt == c_CNT_LAST);
    assign w_pp         = pp_clamp(bus.max_code, bus.min_code);
    assign w_acc_sum    = r_acc + {{(c_ACC_W-c_PP_W){1'b0}}, w_pp};
    assign w_avg_wide   = w_acc_sum >> AVG_LOG2;
    assign w_group_done = w_tick && (r_ncnt == c_N_LAST);

    // Accumulation continues during MUL/LOAD into the freshly cleared acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_ncnt <= '0;
            r_avg  <= '0;
        end else if (w_tick) begin
            if (r_ncnt == c_N_LAST) begin
                r_acc  <= '0;
                r_ncnt <= '0;
                r_avg  <= w_avg_wide[c_PP_W-1:0];
            end else begin
                r_acc  <= w_acc_sum;
                r_ncnt <= r_ncnt + 5'd1;
            end
        end
    end

    vpp_seq_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (r_mul_start),
        .a     (r_avg),
        .b     (MV_PER_LSB_Q8),
        .done  (w_mul_done),
        .p     (w_prod)
    );

    assign w_res_sat = sat_mv(w_prod);

`ifdef VPP_METER_HYST_EN
    logic               r_have_res;
    logic [c_OUT_W-1:0] w_diff;

    assign w_diff   = (w_res_sat >= r_vpp) ? (w_res_sat - r_vpp) : (r_vpp - w_res_sat);
    assign w_update = !r_have_res || (w_diff > HYST_MV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_have_res <= 1'b0;
        end else if ((r_state == ST_LOAD) && w_update) begin
            r_have_res <= 1'b1;
        end
    end
`else
    assign w_update = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_mul_start <= 1'b0;
            r_busy      <= 1'b0;
            r_vld       <= 1'b0;
            r_ovr       <= 1'b0;
            r_vpp       <= '0;
        end else begin
            r_mul_start <= 1'b0;
            if (r_vld && bus.out_rdy) begin
                r_vld <= 1'b0;
            end
            case (r_state)
                ST_ACC: begin
                    if (w_group_done) begin
                        r_state     <= ST_MUL;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_ACC;
                    r_busy  <= 1'b0;
                    // A result loaded in the accept cycle overrides the clear above.
                    if (w_update) begin
                        r_vpp <= w_res_sat;
                        r_vld <= 1'b1;
                        if (r_vld && !bus.out_rdy) begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vpp_mv  = r_vpp;
    assign bus.out_vld = r_vld;
    assign bus.overrun = r_ovr;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vpp_meter.sv
// ============================================================================
// Module : tb_vpp_meter
// Brief  : Bench for vpp_meter: two scale settings against a transaction model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vpp_meter;

    localparam int          c_SP    = 16;
    localparam int          c_AL    = 2;
    localparam int          c_NAVG  = 1 << c_AL;
    localparam logic [15:0] c_MV0   = 16'd1024;
    localparam logic [15:0] c_MV1   = 16'hFFFF;
    localparam logic [15:0] c_HYST  = 16'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] max_code = 9'd0;
    logic [8:0] min_code = 9'h1FF;
    logic       out_rdy  = 1'b1;
    logic       chk_en   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vpp_meter_if bus0 ();
    vpp_meter_if bus1 ();

    assign bus0.max_code = max_code;
    assign bus0.min_code = min_code;
    assign bus0.out_rdy  = out_rdy;
    assign bus1.max_code = max_code;
    assign bus1.min_code = min_code;
    assign bus1.out_rdy  = out_rdy;

    vpp_meter #(.SAMPLE_PERIOD(c_SP), .AVG_LOG2(c_AL), .MV_PER_LSB_Q8(c_MV0), .HYST_MV(c_HYST))
        dut (.clk(clk), .rst(rst), .bus(bus0));

    vpp_meter #(.SAMPLE_PERIOD(c_SP), .AVG_LOG2(c_AL), .MV_PER_LSB_Q8(c_MV1), .HYST_MV(c_HYST))
        dut_sat (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned q_pp[$];
    int unsigned exp_vpp [2];
    bit          exp_vld [2];
    bit          exp_ovr [2];
    bit          have    [2];
    bit          exp_busy;
    longint      pend_due;
    int unsigned pend_avg;
    longint      cyc;

    function automatic int unsigned scale_mv(int unsigned avg, int unsigned mv);
        longint unsigned r;
        r = (longint'(avg) * longint'(mv)) / 256;
        return (r > 65535) ? 65535 : int'(r);
    endfunction

    function automatic bit want_update(int idx, int unsigned val);
`ifdef VPP_METER_HYST_EN
        int d;
        d = int'(val) - int'(exp_vpp[idx]);
        if (d < 0) d = -d;
        return !have[idx] || (d > int'(c_HYST));
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_pp.delete();
            for (int i = 0; i < 2; i++) begin
                exp_vpp[i] = 0; exp_vld[i] = 0; exp_ovr[i] = 0; have[i] = 0;
            end
            exp_busy = 0;
            pend_due = -1;
            pend_avg = 0;
            cyc      = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int unsigned val;
                bit loaded;
                loaded = 0;
                if (pend_due == cyc) begin
                    val = scale_mv(pend_avg, (i == 0) ? c_MV0 : c_MV1);
                    if (want_update(i, val)) begin
                        if (exp_vld[i] && !out_rdy) exp_ovr[i] = 1;
                        exp_vld[i] = 1;
                        exp_vpp[i] = val;
                        have[i]    = 1;
                        loaded     = 1;
                    end
                end
                if (!loaded && exp_vld[i] && out_rdy) exp_vld[i] = 0;
            end
            if (pend_due == cyc) begin
                exp_busy = 0;
                pend_due = -1;
            end
            if ((cyc % c_SP) == c_SP - 1) begin
                int unsigned pp, sum;
                pp = (max_code >= min_code) ? (max_code - min_code) : 0;
                q_pp.push_back(pp);
                if (q_pp.size() == c_NAVG) begin
                    sum = 0;
                    foreach (q_pp[k]) sum += q_pp[k];
                    pend_avg = sum / c_NAVG;
                    pend_due = cyc + 10;
                    exp_busy = 1;
                    q_pp.delete();
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check_val("vpp0",  bus0.vpp_mv,  exp_vpp[0]);
            check_val("vld0",  bus0.out_vld, exp_vld[0]);
            check_val("ovr0",  bus0.overrun, exp_ovr[0]);
            check_val("busy0", bus0.busy,    exp_busy);
            check_val("vpp1",  bus1.vpp_mv,  exp_vpp[1]);
            check_val("vld1",  bus1.out_vld, exp_vld[1]);
            check_val("ovr1",  bus1.overrun, exp_ovr[1]);
            check_val("busy1", bus1.busy,    exp_busy);
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_vpp0"},  bus0.vpp_mv,  0);
        check_val({tag, "_vld0"},  bus0.out_vld, 0);
        check_val({tag, "_ovr0"},  bus0.overrun, 0);
        check_val({tag, "_busy0"}, bus0.busy,    0);
        check_val({tag, "_vpp1"},  bus1.vpp_mv,  0);
        check_val({tag, "_vld1"},  bus1.out_vld, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit seen;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        chk_en = 1'b1;

        // pp = 144 -> 576 mV
        max_code = 9'd200; min_code = 9'd56;
        repeat (144) @(negedge clk);
        check_val("t1_vpp", bus0.vpp_mv, 576);

        // inverted codes clamp to zero amplitude
        max_code = 9'd100; min_code = 9'd300;
        repeat (144) @(negedge clk);
        check_val("t2_vpp", bus0.vpp_mv, 0);

        // full scale; the large multiplier saturates
        max_code = 9'd511; min_code = 9'd0;
        repeat (144) @(negedge clk);
        check_val("t3_vpp0", bus0.vpp_mv, 2044);
        check_val("t3_vpp1", bus1.vpp_mv, 16'hFFFF);

        // consumer stalls across at least two results
        max_code = 9'd200; min_code = 9'd56;
        out_rdy  = 1'b0;
        repeat (200) @(negedge clk);
`ifndef VPP_METER_HYST_EN
        check_val("t4_ovr", bus0.overrun, 1);
        check_val("t4_vld", bus0.out_vld, 1);
        check_val("t4_vpp", bus0.vpp_mv, 576);
`endif
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
`ifndef VPP_METER_HYST_EN
        check_val("t4_ovr_sticky", bus0.overrun, 1);
`endif

        // reset in the middle of a multiply
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus0.busy) seen = 1;
        end
        check_val("t5_busy_seen", seen, 1);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("t5_rst");
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        n = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (bus0.out_vld) seen = 1;
        end
        check_val("t5_vld_seen", seen, 1);
        check_val("t5_latency", n, 74);

`ifdef VPP_METER_HYST_EN
        max_code = 9'd144; min_code = 9'd0;
        repeat (144) @(negedge clk);
        check_val("t6_vpp_a", bus0.vpp_mv, 576);
        max_code = 9'd145;
        repeat (144) @(negedge clk);
        check_val("t6_vpp_b", bus0.vpp_mv, 576);
        max_code = 9'd147;
        repeat (144) @(negedge clk);
        check_val("t6_vpp_c", bus0.vpp_mv, 588);
`endif

        // randomized codes and back-pressure
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) begin
                max_code = 9'($urandom_range(511));
                min_code = 9'($urandom_range(511));
            end
            out_rdy = ($urandom_range(3) != 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
